// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// Imported by the arbiter top level and its byte-beat sequencer.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } arb_state_e;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int BEAT_W = 3;

    // Bit offset of big-endian byte k inside a 32-bit word (24 - 8k).
    function automatic logic [4:0] lane(input logic [1:0] k);
        return {~k, 3'b000};
    endfunction

endpackage

// File: rtl/word_byte_seq.sv
// Byte-beat sequencer: walks four byte addresses from a base (with wrap),
// assembles read bytes into a word, and feeds store bytes one per beat.
module word_byte_seq
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              kind_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [31:0]       wdata_i,
    input  logic [7:0]        rdata_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        wbyte_o,
    output logic              we_o,
    output logic              last_o,
    output logic [31:0]       word_o
);

    localparam logic [BEAT_W-1:0] LAST_WR = BEAT_W'(3);
    localparam logic [BEAT_W-1:0] LAST_RD = BEAT_W'(4);
    localparam logic [BEAT_W-1:0] DRIVE_N = BEAT_W'(3);

    logic              active_q, active_d;
    logic              kind_q, kind_d;
    logic [BEAT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wbyte_q, wbyte_d;
    logic [31:0]       word_q, word_d;

    // Final beat: 3 for a store, 4 for a load (one extra to catch the last byte).
    assign last_o  = active_q && (cnt_q == (kind_q ? LAST_WR : LAST_RD));
    assign we_o    = active_q && kind_q;
    assign addr_o  = addr_q;
    assign wbyte_o = wbyte_q;
    assign word_o  = word_d;

    // Next-state for beat counter, address walk and byte assembly.
    always_comb begin
        active_d = active_q;
        kind_d   = kind_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wbyte_d  = wbyte_q;
        word_d   = word_q;
        if (start_i) begin
            active_d = 1'b1;
            kind_d   = kind_i;
            cnt_d    = '0;
            addr_d   = base_i;
            word_d   = kind_i ? wdata_i : 32'h0;
            if (kind_i) begin
                wbyte_d = wdata_i[31:24];
            end
        end else if (active_q) begin
            if (!kind_q && (cnt_q != '0)) begin
                word_d[lane(2'(cnt_q - 1'b1)) +: 8] = rdata_i;
            end
            if (last_o) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            // Only beats 0..3 present an address; hold it afterwards.
            if (cnt_q < DRIVE_N) begin
                addr_d = addr_q + 1'b1;
                if (kind_q) begin
                    wbyte_d = word_q[lane(2'(cnt_q + 1'b1)) +: 8];
                end
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            kind_q   <= 1'b0;
            cnt_q    <= '0;
            addr_q   <= '0;
            wbyte_q  <= '0;
            word_q   <= '0;
        end else begin
            active_q <= active_d;
            kind_q   <= kind_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wbyte_q  <= wbyte_d;
            word_q   <= word_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates a byte-wide single-port memory between instruction fetch and
// load/store, sequencing each word access as four big-endian byte beats.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              FReq,
    input  logic [31:0]       FAddr,
    output logic              FAck,
    output logic [31:0]       FData,
    input  logic              DReq,
    input  logic              DWrite,
    input  logic [31:0]       DAddr,
    input  logic [31:0]       DWData,
    output logic              DAck,
    output logic [31:0]       DRData,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemWE,
    output logic [7:0]        MemWData,
    input  logic [7:0]        MemRData,
    output logic              Busy
);

    arb_state_e        state_q, state_d;
    logic              port_q, port_d;
    logic              last_grant_q, last_grant_d;
    logic [31:0]       fdata_q, fdata_d;
    logic [31:0]       drdata_q, drdata_d;

    logic              seq_start;
    logic              seq_kind;
    logic [ADDR_W-1:0] seq_base;
    logic              seq_last;
    logic [31:0]       seq_word;

    logic              unused_addr_hi;
    assign unused_addr_hi = ^{FAddr[31:ADDR_W], DAddr[31:ADDR_W]};

    word_byte_seq #(
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clk_i   (CLK),
        .rst_ni  (RST_n),
        .start_i (seq_start),
        .kind_i  (seq_kind),
        .base_i  (seq_base),
        .wdata_i (DWData),
        .rdata_i (MemRData),
        .addr_o  (MemAddr),
        .wbyte_o (MemWData),
        .we_o    (MemWE),
        .last_o  (seq_last),
        .word_o  (seq_word)
    );

    assign FAck   = (state_q == DONE) && (port_q == PORT_F);
    assign DAck   = (state_q == DONE) && (port_q == PORT_D);
    assign FData  = fdata_q;
    assign DRData = drdata_q;
    assign Busy   = (state_q != IDLE);

    // Grant selection and FSM next state; on a tie the last loser wins.
    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        last_grant_d = last_grant_q;
        seq_start    = 1'b0;
        seq_kind     = 1'b0;
        seq_base     = FAddr[ADDR_W-1:0];
        unique case (state_q)
            IDLE: begin
                if (FReq && (!DReq || (last_grant_q == PORT_D))) begin
                    seq_start    = 1'b1;
                    seq_kind     = 1'b0;
                    seq_base     = FAddr[ADDR_W-1:0];
                    port_d       = PORT_F;
                    last_grant_d = PORT_F;
                    state_d      = RD;
                end else if (DReq) begin
                    seq_start    = 1'b1;
                    seq_kind     = DWrite;
                    seq_base     = DAddr[ADDR_W-1:0];
                    port_d       = PORT_D;
                    last_grant_d = PORT_D;
                    state_d      = DWrite ? WR : RD;
                end
            end
            RD, WR: begin
                if (seq_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Publish an assembled read word as the FSM enters DONE.
    always_comb begin
        fdata_d  = fdata_q;
        drdata_d = drdata_q;
        if ((state_q == RD) && seq_last) begin
            if (port_q == PORT_F) begin
                fdata_d = seq_word;
            end else begin
                drdata_d = seq_word;
            end
        end
    end

    // FSM, grant history and read-data registers.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q      <= IDLE;
            port_q       <= PORT_F;
            last_grant_q <= PORT_D;
            fdata_q      <= '0;
            drdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            last_grant_q <= last_grant_d;
            fdata_q      <= fdata_d;
            drdata_q     <= drdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-wide memory model.
// Table of single transactions plus hand sequences for ties and reset.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        FReq = 1'b0;
    logic [31:0] FAddr = '0;
    logic        FAck;
    logic [31:0] FData;
    logic        DReq = 1'b0;
    logic        DWrite = 1'b0;
    logic [31:0] DAddr = '0;
    logic [31:0] DWData = '0;
    logic        DAck;
    logic [31:0] DRData;
    logic [7:0]  MemAddr;
    logic        MemWE;
    logic [7:0]  MemWData;
    logic [7:0]  MemRData;
    logic        Busy;

    logic [7:0]  mem [256];
    logic        load = 1'b1;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(8)) dut (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .FReq     (FReq),
        .FAddr    (FAddr),
        .FAck     (FAck),
        .FData    (FData),
        .DReq     (DReq),
        .DWrite   (DWrite),
        .DAddr    (DAddr),
        .DWData   (DWData),
        .DAck     (DAck),
        .DRData   (DRData),
        .MemAddr  (MemAddr),
        .MemWE    (MemWE),
        .MemWData (MemWData),
        .MemRData (MemRData),
        .Busy     (Busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
        end else begin
            if (MemWE) mem[MemAddr] <= MemWData;
            MemRData <= mem[MemAddr];
        end
    end

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [7:0] a);
        return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
    endfunction

    task automatic run_vec(input vec_t v, input string nm);
        int n = 0;
        int we_n = 0;
        int bad = 0;
        int other = 0;
        logic [31:0] got;
        @(negedge CLK);
        if (v.is_d) begin
            DReq = 1'b1; DWrite = v.wr; DAddr = v.addr; DWData = v.wdata;
        end else begin
            FReq = 1'b1; FAddr = v.addr;
        end
        while (n < 20) begin
            @(posedge CLK);
            n++;
            @(negedge CLK);
            if (MemWE) begin
                if (MemAddr !== 8'(v.addr[7:0] + 8'(we_n)) || n != we_n + 1)
                    bad++;
                we_n++;
            end
            if (v.is_d ? FAck : DAck) other++;
            if (v.is_d ? DAck : FAck) break;
        end
        FReq = 1'b0; DReq = 1'b0; DWrite = 1'b0;
        chk({nm, "_ack_cycle"}, n, v.lat);
        if (v.wr) got = rd_mem(v.addr[7:0]);
        else got = v.is_d ? DRData : FData;
        chk({nm, "_data"}, got, v.exp);
        chk({nm, "_we_beats"}, we_n, v.wr ? 4 : 0);
        chk({nm, "_we_addr"}, bad, 0);
        chk({nm, "_other_ack"}, other, 0);
        @(negedge CLK);
        chk({nm, "_idle"}, 32'(Busy), 0);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_n = 1'b0;
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
    endtask

    vec_t vecs[7];

    initial begin
        int n;
        int k;
        int cnt;
        int busy_n;
        int pt[4];
        int cy[4];

        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0, 32'h1011_1213, 6};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0, 32'hDEAD_BEEF, 6};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0021, 32'h0, 32'hADBE_EF24, 6};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_00FE, 32'hAABB_CCDD, 32'hAABB_CCDD, 5};
        vecs[5] = '{1'b1, 1'b0, 32'h1234_56FE, 32'h0, 32'hAABB_CCDD, 6};
        vecs[6] = '{1'b0, 1'b0, 32'hABCD_EF00, 32'h0, 32'hCCDD_0203, 6};

        repeat (2) @(negedge CLK);
        load = 1'b0;
        @(negedge CLK);
        chk("rst_fack", 32'(FAck), 0);
        chk("rst_dack", 32'(DAck), 0);
        chk("rst_fdata", FData, 0);
        chk("rst_drdata", DRData, 0);
        chk("rst_memaddr", 32'(MemAddr), 0);
        chk("rst_memwe", 32'(MemWE), 0);
        chk("rst_memwdata", 32'(MemWData), 0);
        chk("rst_busy", 32'(Busy), 0);
        RST_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset during the third store beat leaves a partial word.
        @(negedge CLK);
        DReq = 1'b1; DWrite = 1'b1; DAddr = 32'h40; DWData = 32'h1122_3344;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("midrst_we_before", 32'(MemWE), 1);
        chk("midrst_addr_before", 32'(MemAddr), 32'h42);
        RST_n = 1'b0;
        #1;
        chk("midrst_we_after", 32'(MemWE), 0);
        chk("midrst_busy", 32'(Busy), 0);
        DReq = 1'b0; DWrite = 1'b0;
        cnt = 0;
        repeat (3) begin
            @(negedge CLK);
            if (DAck) cnt++;
        end
        RST_n = 1'b1;
        repeat (8) begin
            @(negedge CLK);
            if (DAck) cnt++;
        end
        chk("midrst_no_dack", cnt, 0);
        chk("midrst_partial", rd_mem(8'h40), 32'h1122_4243);
        run_vec('{1'b0, 1'b0, 32'h40, 32'h0, 32'h1122_4243, 6}, "after_rst");

        // Both ports held from reset: fetch first, then strict alternation.
        do_reset();
        @(negedge CLK);
        FReq = 1'b1; FAddr = 32'h10;
        DReq = 1'b1; DWrite = 1'b0; DAddr = 32'h30;
        n = 0;
        k = 0;
        while (n < 60 && k < 4) begin
            @(posedge CLK);
            n++;
            @(negedge CLK);
            if (FAck || DAck) begin
                pt[k] = DAck ? 1 : 0;
                cy[k] = n;
                k++;
            end
        end
        FReq = 1'b0; DReq = 1'b0;
        chk("tie_ack_count", k, 4);
        for (int i = 0; i < k; i++) begin
            chk($sformatf("tie_port%0d", i), pt[i], i % 2);
            chk($sformatf("tie_cycle%0d", i), cy[i], 6 + 7 * i);
        end
        chk("tie_fdata", FData, 32'h1011_1213);
        chk("tie_drdata", DRData, 32'h3031_3233);
        repeat (2) @(negedge CLK);

        // Fetch request held through its ack, dropped on the next edge.
        FReq = 1'b1; FAddr = 32'h08;
        n = 0;
        while (n < 20) begin
            @(posedge CLK);
            n++;
            @(negedge CLK);
            if (FAck) break;
        end
        chk("hold_ack_cycle", n, 6);
        chk("hold_fdata", FData, 32'h0809_0A0B);
        @(posedge CLK);
        #1;
        FReq = 1'b0;
        cnt = 0;
        busy_n = 0;
        repeat (20) begin
            @(negedge CLK);
            if (FAck) cnt++;
            if (Busy) busy_n++;
        end
        chk("hold_no_dup_ack", cnt, 0);
        chk("hold_no_regrant", busy_n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
